// File: rtl/rs_alu_pkg.sv
// Shared widths, the "operand present" tag value and opcode encodings
// for the ALU reservation station and its neighbours.
package rs_alu_pkg;

    localparam int unsigned RS_DEPTH   = 8;
    localparam int unsigned DATA_BUS_W = 32;
    localparam int unsigned TAG_BUS_W  = 4;
    localparam int unsigned NAME_BUS_W = 5;
    localparam int unsigned OP_BUS_W   = 6;
    localparam int unsigned ADDR_BUS_W = 32;

    localparam logic [TAG_BUS_W-1:0] TAG_FREE_VAL = 4'hF;

    localparam logic [OP_BUS_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_BUS_W-1:0] OP_ADD   = 6'd1;
    localparam logic [OP_BUS_W-1:0] OP_SUB   = 6'd2;
    localparam logic [OP_BUS_W-1:0] OP_AND   = 6'd3;
    localparam logic [OP_BUS_W-1:0] OP_OR    = 6'd4;
    localparam logic [OP_BUS_W-1:0] OP_XOR   = 6'd5;
    localparam logic [OP_BUS_W-1:0] OP_SLL   = 6'd6;
    localparam logic [OP_BUS_W-1:0] OP_SRL   = 6'd7;
    localparam logic [OP_BUS_W-1:0] OP_SRA   = 6'd8;
    localparam logic [OP_BUS_W-1:0] OP_SLT   = 6'd9;
    localparam logic [OP_BUS_W-1:0] OP_SLTU  = 6'd10;
    localparam logic [OP_BUS_W-1:0] OP_LUI   = 6'd11;
    localparam logic [OP_BUS_W-1:0] OP_AUIPC = 6'd12;

endpackage

// File: rtl/rs_alu_lowest_one_sel.sv
// Priority encoder: index of the lowest set bit of i_vec, plus a found flag.
module lowest_one_sel #(
    parameter int unsigned W     = 8,
    parameter int unsigned IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (i_vec[i] && !o_found) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched ops, snoops both CDBs for
// pending source tags, issues one operand-ready op per cycle.
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int unsigned           DEPTH    = RS_DEPTH,
    parameter int unsigned           DATA_W   = DATA_BUS_W,
    parameter int unsigned           TAG_W    = TAG_BUS_W,
    parameter logic [TAG_W-1:0]      TAG_FREE = TAG_FREE_VAL,
    parameter int unsigned           NAME_W   = NAME_BUS_W,
    parameter int unsigned           OP_W     = OP_BUS_W,
    parameter int unsigned           ADDR_W   = ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              dispEn,
    input  logic [OP_W-1:0]   dispOp,
    input  logic [DATA_W-1:0] dispValO,
    input  logic [TAG_W-1:0]  dispTagO,
    input  logic [DATA_W-1:0] dispValT,
    input  logic [TAG_W-1:0]  dispTagT,
    input  logic [TAG_W-1:0]  dispWrtTag,
    input  logic [NAME_W-1:0] dispWrtName,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              rsFull,
    input  logic              aluCdbEn,
    input  logic [TAG_W-1:0]  aluCdbTag,
    input  logic [DATA_W-1:0] aluCdbData,
    input  logic              lsuCdbEn,
    input  logic [TAG_W-1:0]  lsuCdbTag,
    input  logic [DATA_W-1:0] lsuCdbData,
    output logic              ALUworkEn,
    output logic [DATA_W-1:0] operandO,
    output logic [DATA_W-1:0] operandT,
    output logic [TAG_W-1:0]  wrtTag,
    output logic [NAME_W-1:0] wrtName,
    output logic [OP_W-1:0]   opCode,
    output logic [ADDR_W-1:0] instAddr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [OP_W-1:0]   r_op      [DEPTH];
    logic [DATA_W-1:0] r_valO    [DEPTH];
    logic [TAG_W-1:0]  r_tagO    [DEPTH];
    logic [DATA_W-1:0] r_valT    [DEPTH];
    logic [TAG_W-1:0]  r_tagT    [DEPTH];
    logic [TAG_W-1:0]  r_wrtTag  [DEPTH];
    logic [NAME_W-1:0] r_wrtName [DEPTH];
    logic [ADDR_W-1:0] r_addr    [DEPTH];

    logic [DEPTH-1:0]  w_ready;
    logic [IDX_W-1:0]  w_freeIdx;
    logic              w_freeFound;
    logic [IDX_W-1:0]  w_issIdx;
    logic              w_issFound;
    logic              w_dispOk;
    logic [DATA_W-1:0] w_byValO;
    logic [TAG_W-1:0]  w_byTagO;
    logic [DATA_W-1:0] w_byValT;
    logic [TAG_W-1:0]  w_byTagT;

    assign rsFull   = &r_busy;
    assign w_dispOk = dispEn && !rsFull && w_freeFound;

    always_comb begin
        w_ready = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_busy[i] && (r_tagO[i] == TAG_FREE) && (r_tagT[i] == TAG_FREE);
        end
    end

    lowest_one_sel #(.W(DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .i_vec   (~r_busy),
        .o_idx   (w_freeIdx),
        .o_found (w_freeFound)
    );

    lowest_one_sel #(.W(DEPTH), .IDX_W(IDX_W)) u_issue_sel (
        .i_vec   (w_ready),
        .o_idx   (w_issIdx),
        .o_found (w_issFound)
    );

    // Same-cycle bypass: a source whose producer broadcasts during dispatch is stored ready.
    always_comb begin
        w_byValO = dispValO;
        w_byTagO = dispTagO;
        w_byValT = dispValT;
        w_byTagT = dispTagT;
        if (dispTagO != TAG_FREE) begin
            if (aluCdbEn && (aluCdbTag == dispTagO)) begin
                w_byValO = aluCdbData;
                w_byTagO = TAG_FREE;
            end else if (lsuCdbEn && (lsuCdbTag == dispTagO)) begin
                w_byValO = lsuCdbData;
                w_byTagO = TAG_FREE;
            end
        end
        if (dispTagT != TAG_FREE) begin
            if (aluCdbEn && (aluCdbTag == dispTagT)) begin
                w_byValT = aluCdbData;
                w_byTagT = TAG_FREE;
            end else if (lsuCdbEn && (lsuCdbTag == dispTagT)) begin
                w_byValT = lsuCdbData;
                w_byTagT = TAG_FREE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            ALUworkEn <= 1'b0;
            operandO  <= '0;
            operandT  <= '0;
            wrtTag    <= TAG_FREE;
            wrtName   <= '0;
            opCode    <= '0;
            instAddr  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_op[i]      <= '0;
                r_valO[i]    <= '0;
                r_tagO[i]    <= TAG_FREE;
                r_valT[i]    <= '0;
                r_tagT[i]    <= TAG_FREE;
                r_wrtTag[i]  <= TAG_FREE;
                r_wrtName[i] <= '0;
                r_addr[i]    <= '0;
            end
        end else if (clr) begin
            r_busy    <= '0;
            ALUworkEn <= 1'b0;
        end else begin
            // Snoop touches only busy entries with pending tags, so it never collides
            // with the issued (fully ready) entry or the free slot being written.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_busy[i]) begin
                    if (r_tagO[i] != TAG_FREE) begin
                        if (aluCdbEn && (aluCdbTag == r_tagO[i])) begin
                            r_valO[i] <= aluCdbData;
                            r_tagO[i] <= TAG_FREE;
                        end else if (lsuCdbEn && (lsuCdbTag == r_tagO[i])) begin
                            r_valO[i] <= lsuCdbData;
                            r_tagO[i] <= TAG_FREE;
                        end
                    end
                    if (r_tagT[i] != TAG_FREE) begin
                        if (aluCdbEn && (aluCdbTag == r_tagT[i])) begin
                            r_valT[i] <= aluCdbData;
                            r_tagT[i] <= TAG_FREE;
                        end else if (lsuCdbEn && (lsuCdbTag == r_tagT[i])) begin
                            r_valT[i] <= lsuCdbData;
                            r_tagT[i] <= TAG_FREE;
                        end
                    end
                end
            end

            if (w_issFound) begin
                ALUworkEn        <= 1'b1;
                operandO         <= r_valO[w_issIdx];
                operandT         <= r_valT[w_issIdx];
                wrtTag           <= r_wrtTag[w_issIdx];
                wrtName          <= r_wrtName[w_issIdx];
                opCode           <= r_op[w_issIdx];
                instAddr         <= r_addr[w_issIdx];
                r_busy[w_issIdx] <= 1'b0;
            end else begin
                ALUworkEn <= 1'b0;
            end

            if (w_dispOk) begin
                r_busy[w_freeIdx]    <= 1'b1;
                r_op[w_freeIdx]      <= dispOp;
                r_valO[w_freeIdx]    <= w_byValO;
                r_tagO[w_freeIdx]    <= w_byTagO;
                r_valT[w_freeIdx]    <= w_byValT;
                r_tagT[w_freeIdx]    <= w_byTagT;
                r_wrtTag[w_freeIdx]  <= dispWrtTag;
                r_wrtName[w_freeIdx] <= dispWrtName;
                r_addr[w_freeIdx]    <= dispAddr;
            end
        end
    end

endmodule
